// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes rx, restarts the mid-bit detector on a start edge,
// then samples start/data/parity/stop on each hit_m and reports the word with a status pulse.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 hit_m,
    output logic                 mb_rst,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int   CNT_W   = 4;
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 par_bad;

    logic hit;
    logic start_det;
    logic cnt_clr;
    logic shift_en;
    logic par_load;
    logic stop_done;

    // Synchronizer and edge-detect flops idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // A strobe coinciding with the detector restart belongs to the previous frame
    assign hit = hit_m & ~mb_rst;

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        stop_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_d && !rx_s) begin
                    state_next = ST_START;
                    start_det  = 1'b1;
                end
            end
            ST_START: begin
                if (hit) begin
                    if (!rx_s) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (hit) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = PAR_ON ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (hit) begin
                    par_load   = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (hit) begin
                    stop_done  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mb_rst     <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_bad    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_next;
            mb_rst     <= start_det;
            data_valid <= stop_done & rx_s & ~par_bad;
            frame_err  <= stop_done & ~rx_s;
            parity_err <= stop_done & rx_s & par_bad;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (par_load) begin
                par_bad <= (^shift_reg) ^ rx_s ^ ODD_BIT;
            end
            if (stop_done) begin
                data <= shift_reg;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 and an 8E1 instance, each fed by a 16x mid-bit detector model,
// with expected results queued per frame and popped by a monitor on every result pulse.
module tb_uart_rx_frame;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic       hit_a, hit_b;
    logic       mb_rst_a, mb_rst_b;
    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, fe_a, fe_b, pe_a, pe_b;
    logic       busy_a, busy_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mb_cnt_a = 0;
    int   mb_cnt_b = 0;
    int   vprev_a  = 0;
    int   vlast_a  = 0;
    int   ph_a, ph_b;
    bit   run_a, run_b;
    exp_t exp_a[$];
    exp_t exp_b[$];

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .hit_m(hit_a), .mb_rst(mb_rst_a),
        .data(data_a), .data_valid(dv_a), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .hit_m(hit_b), .mb_rst(mb_rst_b),
        .data(data_b), .data_valid(dv_b), .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mid-bit detector models: first strobe 8 clocks after restart, then every 16
    initial begin
        hit_a = 1'b0; ph_a = 0; run_a = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_a = 1'b0; hit_a = 1'b0;
            end else if (mb_rst_a) begin
                ph_a = 0; run_a = 1'b1; hit_a = 1'b0;
            end else if (run_a) begin
                ph_a++;
                hit_a = (ph_a >= 8) && (((ph_a - 8) % 16) == 0);
            end else begin
                hit_a = 1'b0;
            end
        end
    end

    initial begin
        hit_b = 1'b0; ph_b = 0; run_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_b = 1'b0; hit_b = 1'b0;
            end else if (mb_rst_b) begin
                ph_b = 0; run_b = 1'b1; hit_b = 1'b0;
            end else if (run_b) begin
                ph_b++;
                hit_b = (ph_b >= 8) && (((ph_b - 8) % 16) == 0);
            end else begin
                hit_b = 1'b0;
            end
        end
    end

    // Monitors: kind 0 = data_valid, 1 = frame_err, 2 = parity_err
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst_n) begin
            if (mb_rst_a) mb_cnt_a++;
            if (dv_a || fe_a || pe_a) begin
                kind = dv_a ? 0 : (fe_a ? 1 : 2);
                check_output("a_onehot", $countones({dv_a, fe_a, pe_a}), 1);
                if (exp_a.size() == 0) begin
                    check_output("a_unexpected_pulse", kind + 16, 32'hff);
                end else begin
                    e = exp_a.pop_front();
                    check_output("a_kind", kind, e.kind);
                    check_output("a_data", data_a, e.data);
                end
                if (dv_a) begin
                    vprev_a = vlast_a;
                    vlast_a = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (rst_n) begin
            if (mb_rst_b) mb_cnt_b++;
            if (dv_b || fe_b || pe_b) begin
                kind = dv_b ? 0 : (fe_b ? 1 : 2);
                check_output("b_onehot", $countones({dv_b, fe_b, pe_b}), 1);
                if (exp_b.size() == 0) begin
                    check_output("b_unexpected_pulse", kind + 16, 32'hff);
                end else begin
                    e = exp_b.pop_front();
                    check_output("b_kind", kind, e.kind);
                    check_output("b_data", data_b, e.data);
                end
            end
        end
    end

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rx_a = b;
        else            rx_b = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic expect_frame(input int which, input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        if (which == 0) exp_a.push_back(e);
        else            exp_b.push_back(e);
    endtask

    task automatic apply_stimulus(input int which, input logic [7:0] d, input bit par_en,
                                  input logic par_bit, input logic stop_bit);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (par_en) drive_bit(which, par_bit);
        drive_bit(which, stop_bit);
    endtask

    task automatic idle(input int n);
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int m0;
        int busy_cycles;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_a_outputs", {mb_rst_a, dv_a, fe_a, pe_a, busy_a}, 0);
        check_output("reset_a_data", data_a, 0);
        check_output("reset_b_outputs", {mb_rst_b, dv_b, fe_b, pe_b, busy_b}, 0);
        check_output("reset_b_data", data_b, 0);
        rst_n = 1'b1;
        idle(20);

        $display("[TB] frame 0xA5 8N1");
        m0 = mb_cnt_a;
        expect_frame(0, 0, 8'hA5);
        apply_stimulus(0, 8'hA5, 0, 1'b0, 1'b1);
        idle(10);
        check_output("a5_mb_rst_count", mb_cnt_a - m0, 1);
        check_output("a5_busy_after", busy_a, 0);
        check_output("a5_data_held", data_a, 8'hA5);

        $display("[TB] false start");
        busy_cycles = 0;
        rx_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy_a) busy_cycles++;
        end
        rx_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_a) busy_cycles++;
        end
        check_output("false_start_entered", busy_cycles > 0, 1);
        check_output("false_start_short", busy_cycles < 16, 1);
        check_output("false_start_data", data_a, 8'hA5);
        idle(20);

        $display("[TB] frame 0x3C with low stop bit then break");
        expect_frame(0, 1, 8'h3C);
        apply_stimulus(0, 8'h3C, 0, 1'b0, 1'b0);
        m0 = mb_cnt_a;
        rx_a = 1'b0;
        repeat (80) @(negedge clk);
        check_output("break_no_restart", mb_cnt_a - m0, 0);
        check_output("break_not_busy", busy_a, 0);
        check_output("break_data", data_a, 8'h3C);
        idle(32);

        $display("[TB] back-to-back 0x55, 0xAA");
        expect_frame(0, 0, 8'h55);
        expect_frame(0, 0, 8'hAA);
        apply_stimulus(0, 8'h55, 0, 1'b0, 1'b1);
        apply_stimulus(0, 8'hAA, 0, 1'b0, 1'b1);
        idle(10);
        check_output("b2b_spacing", vlast_a - vprev_a, 160);
        check_output("b2b_last_data", data_a, 8'hAA);
        idle(20);

        $display("[TB] reset during data bit 4 of 0xFF");
        m0 = failures;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        repeat (3) @(negedge clk);
        check_output("abort_data_reset", data_a, 0);
        check_output("abort_busy_reset", busy_a, 0);
        rst_n = 1'b1;
        idle(30);
        check_output("abort_no_pulse_data", data_a, 0);
        expect_frame(0, 0, 8'h12);
        apply_stimulus(0, 8'h12, 0, 1'b0, 1'b1);
        idle(10);
        check_output("after_abort_data", data_a, 8'h12);

        $display("[TB] even parity instance");
        expect_frame(1, 0, 8'h07);
        apply_stimulus(1, 8'h07, 1, 1'b1, 1'b1);
        idle(20);
        expect_frame(1, 2, 8'h07);
        apply_stimulus(1, 8'h07, 1, 1'b0, 1'b1);
        idle(20);
        check_output("parity_err_data", data_b, 8'h07);
        expect_frame(1, 0, 8'h00);
        apply_stimulus(1, 8'h00, 1, 1'b0, 1'b1);
        idle(20);
        expect_frame(1, 2, 8'hC3);
        apply_stimulus(1, 8'hC3, 1, 1'b1, 1'b1);
        idle(20);
        expect_frame(1, 1, 8'h81);
        apply_stimulus(1, 8'h81, 1, 1'b0, 1'b0);
        idle(40);

        check_output("a_queue_drained", exp_a.size(), 0);
        check_output("b_queue_drained", exp_b.size(), 0);
        check_output("a_no_stray_pulse_a", busy_a, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
